// File: rtl/apb_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_fifo_pkg : shared defaults and types for the APB FIFO            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package apb_fifo_pkg;

  localparam int WIDTH_DFLT = 32;
  localparam int DEPTH_DFLT = 8;
  localparam int PTR_W      = $clog2(DEPTH_DFLT) + 1;

  typedef logic [WIDTH_DFLT-1:0] data_t;
  typedef logic [PTR_W-1:0]      ptr_t;

endpackage
`default_nettype wire

// File: rtl/apb_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_fifo_mem : register array, synchronous write / async read        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module apb_fifo_mem
  import apb_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DFLT,
  parameter int DEPTH = DEPTH_DFLT
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/apb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_fifo : FWFT FIFO behind apb_slave; sticky error flags built only |
// | when APB_FIFO_ERR_FLAGS_EN is defined.               Rev 1.0         |
// +----------------------------------------------------------------------+
module apb_fifo
  import apb_fifo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DFLT,
  parameter int DEPTH     = DEPTH_DFLT,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   write,
  input  logic [WIDTH-1:0]       data_write,
  input  logic                   read,
  output logic [WIDTH-1:0]       data_read,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int                 c_PTR_W = $clog2(DEPTH) + 1;
  localparam int                 c_AW    = c_PTR_W - 1;
  localparam logic [c_PTR_W-1:0] c_DEPTH = c_PTR_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_AFULL = c_PTR_W'(AFULL_LVL);

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == c_DEPTH);
  assign w_empty = (w_count == '0);

  // A push into a full FIFO is allowed when the head leaves on the same edge.
  assign w_push = write & (~w_full | read);
  assign w_pop  = read & ~w_empty;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  apb_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (PCLK),
    .i_we    (w_push & ~PRESET),
    .i_waddr (r_wr_ptr[c_AW-1:0]),
    .i_wdata (data_write),
    .i_raddr (r_rd_ptr[c_AW-1:0]),
    .o_rdata (data_read)
  );

  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (w_count >= c_AFULL);
  assign count       = w_count;

`ifdef APB_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write & w_full & ~read) r_overflow  <= 1'b1;
      if (read & w_empty)         r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/apb_fifo.md
# apb_fifo

Synchronous first-word-fall-through FIFO directly downstream of `apb_slave`. It stores words written through the APB write path and presents the head word for the APB read path. It drives the `full`/`empty` status that `apb_slave` uses to raise `PSLVERR`. It consumes the `write`/`data_write` strobes and produces `data_read` in the same access phase.

## Interface
- `WIDTH`, 32, data word width in bits.
- `DEPTH`, 8, number of entries; must be a power of two, at least 2.
- `AFULL_LVL`, DEPTH-1, `almost_full` asserts when `count` is at least this value.
- `PCLK` input 1: the single clock; all state updates on its rising edge.
- `PRESET` input 1: reset, synchronous and active-high.
- `write` input 1: push strobe from `apb_slave`, one word per cycle it is high.
- `data_write` input WIDTH: word to push; sampled only when `write`=1.
- `read` input 1: pop strobe from `apb_slave`.
- `data_read` output WIDTH: head entry, valid whenever `empty`=0.
- `full` output 1: `count`==DEPTH.
- `empty` output 1: `count`==0.
- `almost_full` output 1: `count`>=AFULL_LVL.
- `count` output $clog2(DEPTH)+1: number of stored words.
- `overflow` output 1: sticky error flag (see Configuration).
- `underflow` output 1: sticky error flag (see Configuration).

## Operation
- Storage: DEPTH×WIDTH register array.
  - `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits wide.
  - The MSB of each pointer is the wrap bit. Indexing uses the low bits and wraps modulo DEPTH with no special case.
- Accepted push: `write`=1 and (`full`=0 or `read`=1).
  - `mem[wr_ptr]` <= `data_write`.
  - `wr_ptr` increments.
- Accepted pop: `read`=1 and `empty`=0.
  - `rd_ptr` increments.
- `count` = `wr_ptr` − `rd_ptr`, modulo 2^(ptr width). All status outputs derive combinationally from the pointers.
- Simultaneous events:
  - Read+write while full: both accepted; `count` unchanged.
  - Read+write while empty: push accepted, pop rejected (underflow event); `count` becomes 1.
  - Otherwise both are accepted.
- Rejected push: `write`=1, `full`=1, `read`=0. Memory and pointers are unchanged; this is an overflow event.
- Rejected pop: `read`=1, `empty`=1. This is an underflow event.
- `data_read` = `mem[rd_ptr]`, combinational from registered state. When `empty`=1 it holds the stale last-written slot; consumers must ignore it.
- Reset:
  - Clears `wr_ptr`, `rd_ptr` and both error flags.
  - Memory contents are not cleared.
  - Reset wins over `write`/`read` in the same cycle. Any words in flight are discarded.

## Timing
- After reset:
  - `empty`=1, `full`=0, `almost_full`=0 (0 when AFULL_LVL is at least 1).
  - `count`=0, `overflow`=0, `underflow`=0.
  - `data_read` is undefined content.
- Push to visibility: a word pushed at edge N appears on `data_read` after edge N if the FIFO was empty. `empty` falls after the same edge.
- Pop: `data_read` advances to the next entry after the popping edge. The current head is valid during the cycle `read` is high, which matches the APB access phase.
- `full`/`empty`/`count` update one edge after the accepted operation. There is no combinational path from `write`/`read` to any output.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- Macro: `APB_FIFO_ERR_FLAGS_EN`.
- Defined:
  - `overflow` sets on a rejected push; `underflow` sets on a rejected pop.
  - Both are sticky until `PRESET`.
- Undefined: `overflow` and `underflow` are tied to 0 and the sticky registers are not built. Ports remain so the instantiation is identical.

## Structure
- `apb_fifo_pkg`:
  - `WIDTH`/`DEPTH` defaults.
  - `PTR_W` = $clog2(DEPTH)+1.
  - Typedefs `data_t` (logic [WIDTH-1:0]) and `ptr_t`.
- Sub-module `apb_fifo_mem`: write-enable register array with synchronous write and asynchronous read port.
- Pointer, status and flag logic stays in `apb_fifo`.

## Test plan
- Reset then idle: `empty`=1, `full`=0, `count`=0 for 5 cycles; then 1 push of 32'hA5 → `data_read`=32'hA5, `empty`=0, `count`=1.
- Fill: push 0..7 → `full`=1 after the 8th edge, `almost_full`=1 from `count`=7. Pop 8 times → reads 0..7 in order, `empty`=1.
- Wrap: 3 rounds of push 5 / pop 5 using values i*10 → every read matches, pointers wrap, `count` returns to 0.
- Full + read&write with 32'hFC: `count` stays 8. The head pops, and 32'hFC is read last after draining.
- Errors (macro defined): push 32'hFD when full → contents unchanged, `overflow`=1. Pop when empty → `underflow`=1. Both stay set until `PRESET`.
- Reset mid-operation: 4 words stored, assert `PRESET` together with `write`=1 → `count`=0, `empty`=1, the write is discarded and flags are cleared.
